// File: rtl/rggen_rtl_pkg.sv
// Shared rggen bus types (access kind, response status) and the strobe-to-bit-mask helper
// used by every block that turns bus strobes into write enables.
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_READ         = 2'b00,
    RGGEN_POSTED_WRITE = 2'b10,
    RGGEN_WRITE        = 2'b11
  } rggen_access;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  localparam int RGGEN_MAX_BUS_WIDTH = 256;

  // Callers zero-extend their strobe into the wide argument and truncate the result back to
  // their own bus width, so one function serves every bus width up to RGGEN_MAX_BUS_WIDTH.
  function automatic logic [RGGEN_MAX_BUS_WIDTH-1:0] rggen_expand_strobe(
    input logic [RGGEN_MAX_BUS_WIDTH-1:0] strobe,
    input int                             bus_width,
    input int                             strobe_width
  );
    logic [RGGEN_MAX_BUS_WIDTH-1:0] mask;
    mask = '0;
    if (strobe_width == bus_width) begin
      mask = strobe;
    end else begin
      for (int i = 0; i < RGGEN_MAX_BUS_WIDTH / 8; i++) begin
        mask[8*i+:8] = {8{strobe[i]}};
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/rggen_bus_if.sv
// rggen_bus_if: generic register bus between a bus master and a register/window slave.
interface rggen_bus_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int STROBE_WIDTH  = BUS_WIDTH / 8
);

  logic                       valid;
  rggen_rtl_pkg::rggen_access access;
  logic [ADDRESS_WIDTH-1:0]   address;
  logic [BUS_WIDTH-1:0]       write_data;
  logic [STROBE_WIDTH-1:0]    strobe;
  logic                       ready;
  rggen_rtl_pkg::rggen_status status;
  logic [BUS_WIDTH-1:0]       read_data;

  modport master (
    output valid, access, address, write_data, strobe,
    input  ready, status, read_data
  );

  modport slave (
    input  valid, access, address, write_data, strobe,
    output ready, status, read_data
  );

  modport monitor (
    input valid, access, address, write_data, strobe,
    input ready, status, read_data
  );

endinterface

// File: rtl/rggen_external_bus_responder_timer.sv
// Ack timeout counter for rggen_external_bus_responder; only instantiated when
// RGGEN_EXTERNAL_BUS_RESPONDER_TIMEOUT_EN is defined.
module rggen_external_bus_responder_timer #(
  parameter int TIMEOUT_CYCLES = 255
)(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_count_up,
  output logic o_expired
);

  localparam int COUNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [COUNT_WIDTH-1:0] count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      count <= '0;
    end else if (i_count_up) begin
      count <= count + 1'b1;
    end
  end

  // Expiry is flagged in the cycle whose increment would make the count reach the limit.
  assign o_expired = i_count_up && (count == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/rggen_external_bus_responder.sv
// Slave endpoint of rggen_bus_if serving requests from a native memory port with variable ack latency.
// Optional ack timeout: define RGGEN_EXTERNAL_BUS_RESPONDER_TIMEOUT_EN.
import rggen_rtl_pkg::*;

module rggen_external_bus_responder #(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int STROBE_WIDTH   = BUS_WIDTH / 8,
  parameter int BYTE_SIZE      = 256,
  parameter int TIMEOUT_CYCLES = 255
)(
  input  logic                                            i_clk,
  input  logic                                            i_rst,
  rggen_bus_if.slave                                      bus_if,
  output logic                                            o_mem_req,
  output logic                                            o_mem_write,
  output logic [ADDRESS_WIDTH-$clog2(BUS_WIDTH/8)-1:0]    o_mem_address,
  output logic [BUS_WIDTH-1:0]                            o_mem_write_data,
  output logic [BUS_WIDTH-1:0]                            o_mem_mask,
  input  logic                                            i_mem_ack,
  input  logic                                            i_mem_error,
  input  logic [BUS_WIDTH-1:0]                            i_mem_read_data
);

  localparam int WORD_LSB = $clog2(BUS_WIDTH / 8);
  localparam logic [ADDRESS_WIDTH:0] BYTE_LIMIT = (ADDRESS_WIDTH + 1)'(BYTE_SIZE);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]           state;
  logic                 write_access;
  logic                 out_of_range;
  logic                 no_strobe;
  logic                 timeout;
  logic [BUS_WIDTH-1:0] strobe_mask;
  rggen_status          status;
  logic [BUS_WIDTH-1:0] read_data;

  assign write_access = bus_if.access != RGGEN_READ;
  assign out_of_range = {1'b0, bus_if.address} >= BYTE_LIMIT;
  assign no_strobe    = bus_if.strobe == '0;
  assign strobe_mask  = BUS_WIDTH'(rggen_expand_strobe(
                          RGGEN_MAX_BUS_WIDTH'(bus_if.strobe), BUS_WIDTH, STROBE_WIDTH));

`ifdef RGGEN_EXTERNAL_BUS_RESPONDER_TIMEOUT_EN
  rggen_external_bus_responder_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (state != REQ),
    .i_count_up ((state == REQ) && !i_mem_ack),
    .o_expired  (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Requests that can be answered without the memory (range error, empty write) skip REQ.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= IDLE;
      o_mem_write      <= 1'b0;
      o_mem_address    <= '0;
      o_mem_write_data <= '0;
      o_mem_mask       <= '0;
      status           <= RGGEN_OKAY;
      read_data        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus_if.valid) begin
            o_mem_write      <= write_access;
            o_mem_address    <= bus_if.address[ADDRESS_WIDTH-1:WORD_LSB];
            o_mem_write_data <= bus_if.write_data;
            o_mem_mask       <= write_access ? strobe_mask : '0;
            if (out_of_range) begin
              state     <= RESP;
              status    <= RGGEN_SLAVE_ERROR;
              read_data <= '0;
            end else if (write_access && no_strobe) begin
              state     <= RESP;
              status    <= RGGEN_OKAY;
              read_data <= '0;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (i_mem_ack) begin
            state     <= RESP;
            status    <= i_mem_error ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;
            read_data <= o_mem_write ? '0 : i_mem_read_data;
          end else if (timeout) begin
            state     <= RESP;
            status    <= RGGEN_SLAVE_ERROR;
            read_data <= '0;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign o_mem_req        = state == REQ;
  assign bus_if.ready     = state == RESP;
  assign bus_if.status    = status;
  assign bus_if.read_data = read_data;

endmodule

// File: tb/tb_rggen_external_bus_responder.sv
// Directed self-checking bench for rggen_external_bus_responder (16-bit address, 32-bit bus,
// 256-byte window, TIMEOUT_CYCLES=4 when the timeout macro is defined).
import rggen_rtl_pkg::*;

module tb_rggen_external_bus_responder;

  localparam int AW = 16;
  localparam int BW = 32;
  localparam int SW = 4;

  logic          clk;
  logic          rst;
  logic          mem_req;
  logic          mem_write;
  logic [AW-3:0] mem_address;
  logic [BW-1:0] mem_write_data;
  logic [BW-1:0] mem_mask;
  logic          mem_ack;
  logic          mem_error;
  logic [BW-1:0] mem_read_data;

  int passes = 0;
  int checks = 0;

  int            readyCycle;
  int            reqCycles;
  logic          reqStable;
  logic [1:0]    rspStatus;
  logic [BW-1:0] rspData;
  logic [AW-3:0] memAddr;
  logic [BW-1:0] memMask;
  logic [BW-1:0] memWdata;
  logic          memWrite;
  logic          readySeen;
  logic          reqSeen;

  rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .STROBE_WIDTH(SW)) bus_if ();

  rggen_external_bus_responder #(
    .ADDRESS_WIDTH  (AW),
    .BUS_WIDTH      (BW),
    .STROBE_WIDTH   (SW),
    .BYTE_SIZE      (256),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .bus_if           (bus_if.slave),
    .o_mem_req        (mem_req),
    .o_mem_write      (mem_write),
    .o_mem_address    (mem_address),
    .o_mem_write_data (mem_write_data),
    .o_mem_mask       (mem_mask),
    .i_mem_ack        (mem_ack),
    .i_mem_error      (mem_error),
    .i_mem_read_data  (mem_read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) begin
      passes++;
    end else begin
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one request (cycle 0), answers it as a memory acking ackDelay cycles after
  // o_mem_req rises (negative = never), and records what the DUT did, cycle by cycle.
  task automatic applyStimulus(input rggen_access access, input logic [AW-1:0] address,
                               input logic [BW-1:0] data, input logic [SW-1:0] strobe,
                               input int ackDelay, input logic ackError,
                               input logic [BW-1:0] ackData, input int budget);
    readyCycle = -1;
    reqCycles  = 0;
    reqStable  = 1'b1;
    rspStatus  = '0;
    rspData    = '0;
    memAddr    = '0;
    memMask    = '0;
    memWdata   = '0;
    memWrite   = 1'b0;
    @(posedge clk);
    #1;
    bus_if.valid      = 1'b1;
    bus_if.access     = access;
    bus_if.address    = address;
    bus_if.write_data = data;
    bus_if.strobe     = strobe;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(posedge clk);
      #1;
      if (bus_if.ready) begin
        readyCycle = cyc;
        rspStatus  = bus_if.status;
        rspData    = bus_if.read_data;
        break;
      end
      if (mem_req) begin
        if (reqCycles == 0) begin
          memAddr  = mem_address;
          memMask  = mem_mask;
          memWdata = mem_write_data;
          memWrite = mem_write;
        end else if (mem_address !== memAddr || mem_mask !== memMask ||
                     mem_write_data !== memWdata || mem_write !== memWrite) begin
          reqStable = 1'b0;
        end
        mem_ack       = (reqCycles == ackDelay);
        mem_error     = ackError;
        mem_read_data = ackData;
        reqCycles++;
      end else begin
        mem_ack = 1'b0;
      end
    end
    mem_ack   = 1'b0;
    mem_error = 1'b0;
    if (readyCycle >= 0) begin
      @(posedge clk);
      #1;
      bus_if.valid = 1'b0;
    end
  endtask

  initial begin
    rst               = 1'b1;
    mem_ack           = 1'b0;
    mem_error         = 1'b0;
    mem_read_data     = '0;
    bus_if.valid      = 1'b0;
    bus_if.access     = RGGEN_READ;
    bus_if.address    = '0;
    bus_if.write_data = '0;
    bus_if.strobe     = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready",     64'(bus_if.ready), 64'(0));
    checkOutput("rst_status",    64'(bus_if.status), 64'(RGGEN_OKAY));
    checkOutput("rst_read_data", 64'(bus_if.read_data), 64'(0));
    checkOutput("rst_mem_req",   64'(mem_req), 64'(0));
    checkOutput("rst_mem_write", 64'(mem_write), 64'(0));
    checkOutput("rst_mem_addr",  64'(mem_address), 64'(0));
    checkOutput("rst_mem_wdata", 64'(mem_write_data), 64'(0));
    checkOutput("rst_mem_mask",  64'(mem_mask), 64'(0));
    rst = 1'b0;

    // Write, low half-word strobe, combinational ack
    applyStimulus(RGGEN_WRITE, 16'h0004, 32'hDEADBEEF, 4'b0011, 0, 1'b0, 32'h0, 50);
    checkOutput("t1_mem_addr",   64'(memAddr), 64'(1));
    checkOutput("t1_mem_mask",   64'(memMask), 64'h0000FFFF);
    checkOutput("t1_mem_write",  64'(memWrite), 64'(1));
    checkOutput("t1_mem_wdata",  64'(memWdata), 64'hDEADBEEF);
    checkOutput("t1_ready_cyc",  64'(readyCycle), 64'(2));
    checkOutput("t1_status",     64'(rspStatus), 64'(RGGEN_OKAY));
    checkOutput("t1_ready_once", 64'(bus_if.ready), 64'(0));

    // Read acked 5 cycles after the request rises
    applyStimulus(RGGEN_READ, 16'h0008, 32'h0, 4'b0000, 5, 1'b0, 32'h12345678, 50);
    checkOutput("t2_mem_addr",   64'(memAddr), 64'(2));
    checkOutput("t2_mem_mask",   64'(memMask), 64'(0));
    checkOutput("t2_mem_write",  64'(memWrite), 64'(0));
    checkOutput("t2_req_cycles", 64'(reqCycles), 64'(6));
    checkOutput("t2_req_stable", 64'(reqStable), 64'(1));
    checkOutput("t2_ready_cyc",  64'(readyCycle), 64'(7));
    checkOutput("t2_read_data",  64'(rspData), 64'h12345678);
    checkOutput("t2_status",     64'(rspStatus), 64'(RGGEN_OKAY));

    // First out-of-range offset
    applyStimulus(RGGEN_READ, 16'h0100, 32'h0, 4'b0000, 0, 1'b0, 32'hFFFFFFFF, 50);
    checkOutput("t3_req_cycles", 64'(reqCycles), 64'(0));
    checkOutput("t3_ready_cyc",  64'(readyCycle), 64'(1));
    checkOutput("t3_status",     64'(rspStatus), 64'(RGGEN_SLAVE_ERROR));
    checkOutput("t3_read_data",  64'(rspData), 64'(0));

    // Last in-range byte, posted write, top byte strobe; sub-word bits dropped
    applyStimulus(RGGEN_POSTED_WRITE, 16'h00FF, 32'hA1B2C3D4, 4'b1000, 1, 1'b0, 32'h0, 50);
    checkOutput("t3b_mem_addr",  64'(memAddr), 64'h3F);
    checkOutput("t3b_mem_mask",  64'(memMask), 64'hFF000000);
    checkOutput("t3b_mem_write", 64'(memWrite), 64'(1));
    checkOutput("t3b_ready_cyc", 64'(readyCycle), 64'(3));
    checkOutput("t3b_status",    64'(rspStatus), 64'(RGGEN_OKAY));

    // Read answered with an error
    applyStimulus(RGGEN_READ, 16'h0010, 32'h0, 4'b0000, 1, 1'b1, 32'hCAFE0000, 50);
    checkOutput("t4_ready_cyc",  64'(readyCycle), 64'(3));
    checkOutput("t4_status",     64'(rspStatus), 64'(RGGEN_SLAVE_ERROR));

    // Write with all strobes clear never reaches the memory
    applyStimulus(RGGEN_WRITE, 16'h0014, 32'h55555555, 4'b0000, 0, 1'b0, 32'h0, 50);
    checkOutput("t4b_req_cycles", 64'(reqCycles), 64'(0));
    checkOutput("t4b_ready_cyc",  64'(readyCycle), 64'(1));
    checkOutput("t4b_status",     64'(rspStatus), 64'(RGGEN_OKAY));

    // Full write after an error: status recovers, read_data cleared
    applyStimulus(RGGEN_WRITE, 16'h0018, 32'h01020304, 4'b1111, 2, 1'b0, 32'h77777777, 50);
    checkOutput("t4c_mem_mask",  64'(memMask), 64'hFFFFFFFF);
    checkOutput("t4c_ready_cyc", 64'(readyCycle), 64'(4));
    checkOutput("t4c_status",    64'(rspStatus), 64'(RGGEN_OKAY));
    checkOutput("t4c_read_data", 64'(rspData), 64'(0));

`ifdef RGGEN_EXTERNAL_BUS_RESPONDER_TIMEOUT_EN
    applyStimulus(RGGEN_READ, 16'h0020, 32'h0, 4'b0000, -1, 1'b0, 32'h99999999, 50);
    checkOutput("t5_req_cycles", 64'(reqCycles), 64'(4));
    checkOutput("t5_ready_cyc",  64'(readyCycle), 64'(5));
    checkOutput("t5_status",     64'(rspStatus), 64'(RGGEN_SLAVE_ERROR));
    checkOutput("t5_read_data",  64'(rspData), 64'(0));

    // Ack arriving in the expiry cycle wins over the timeout
    applyStimulus(RGGEN_READ, 16'h0024, 32'h0, 4'b0000, 3, 1'b0, 32'h13579BDF, 50);
    checkOutput("t5b_ready_cyc", 64'(readyCycle), 64'(5));
    checkOutput("t5b_status",    64'(rspStatus), 64'(RGGEN_OKAY));
    checkOutput("t5b_read_data", 64'(rspData), 64'h13579BDF);
`else
    applyStimulus(RGGEN_READ, 16'h0020, 32'h0, 4'b0000, -1, 1'b0, 32'h0, 1000);
    checkOutput("t5_no_ready",   64'(readyCycle), 64'(-1));
    checkOutput("t5_req_cycles", 64'(reqCycles), 64'(1000));
    checkOutput("t5_req_held",   64'(mem_req), 64'(1));
    mem_ack       = 1'b1;
    mem_read_data = 32'hA5A55A5A;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    checkOutput("t5_late_ready", 64'(bus_if.ready), 64'(1));
    checkOutput("t5_late_data",  64'(bus_if.read_data), 64'hA5A55A5A);
    @(posedge clk);
    #1;
    bus_if.valid = 1'b0;
`endif

    // Reset while the request is outstanding
    @(posedge clk);
    #1;
    bus_if.valid   = 1'b1;
    bus_if.access  = RGGEN_READ;
    bus_if.address = 16'h000C;
    @(posedge clk);
    #1;
    checkOutput("t6_req_active", 64'(mem_req), 64'(1));
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus_if.valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("t6_req_dropped", 64'(mem_req), 64'(0));
    checkOutput("t6_no_ready",    64'(bus_if.ready), 64'(0));
    readySeen = 1'b0;
    reqSeen   = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      readySeen = readySeen | bus_if.ready;
      reqSeen   = reqSeen | mem_req;
    end
    checkOutput("t6_ready_quiet", 64'(readySeen), 64'(0));
    checkOutput("t6_req_quiet",   64'(reqSeen), 64'(0));

    applyStimulus(RGGEN_READ, 16'h000C, 32'h0, 4'b0000, 2, 1'b0, 32'h0BADF00D, 50);
    checkOutput("t6_mem_addr",  64'(memAddr), 64'(3));
    checkOutput("t6_ready_cyc", 64'(readyCycle), 64'(4));
    checkOutput("t6_read_data", 64'(rspData), 64'h0BADF00D);
    checkOutput("t6_status",    64'(rspStatus), 64'(RGGEN_OKAY));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
